// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared FSM encoding and spi_if bus field layout for spi_arbiter
package spi_arb_pkg;

    localparam int CFG_W        = 11;
    localparam int DIN_W        = 11;
    localparam int DIN_DATA_LSB = 0;
    localparam int DIN_START    = 8;
    localparam int DIN_STOP     = 9;
    localparam int DIN_RX       = 10;
    localparam int DOUT_W       = 9;
    localparam int DOUT_EMPTY   = 8;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CFG     = 4'd1,
        ST_CFG_ACK = 4'd2,
        ST_TXW     = 4'd3,
        ST_WR      = 4'd4,
        ST_WR_ACK  = 4'd5,
        ST_RD      = 4'd6,
        ST_RD_ACK  = 4'd7,
        ST_DONE    = 4'd8
    } arb_state_e;

    function automatic logic [DIN_W-1:0] wr_word(
        input logic       rx,
        input logic       last,
        input logic       first,
        input logic [7:0] data
    );
        logic [DIN_W-1:0] w;
        w                      = '0;
        w[DIN_DATA_LSB +: 8]   = data;
        w[DIN_START]           = first;
        w[DIN_STOP]            = last;
        w[DIN_RX]              = rx;
        return w;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr.sv
// rtl/spi_arbiter_rr.sv - round-robin picker: lowest requester at/after the pointer wins
// The pointer moves past the winner only when the caller accepts the grant.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            any_req
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;
    logic [IDXW-1:0] cand;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IDXW'((int'(ptr_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                gnt[cand]   = 1'b1;
                gnt_idx     = cand;
            end
        end
    end

    assign any_req = found;

    always_comb begin
        ptr_d = ptr_q;
        if (accept && found) begin
            ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - shares one spi_if among NREQ requesters, one whole SPI transaction per grant
// Build option SPI_ARB_CFG_CACHE_EN: skip the cfg command when the winner's cfg equals the last one written.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LENW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*11-1:0]   req_cfg,
    input  logic [NREQ*LENW-1:0] req_len,
    input  logic [NREQ-1:0]      req_rx,
    input  logic [NREQ*8-1:0]    tx_data,
    input  logic [NREQ-1:0]      tx_valid,
    output logic [NREQ-1:0]      tx_ready,
    output logic [7:0]           rx_data,
    output logic [NREQ-1:0]      rx_valid,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [10:0]          spi_din,
    output logic                 spi_cmd,
    output logic                 spi_wr,
    output logic                 spi_rd,
    input  logic [8:0]           spi_dout,
    input  logic                 spi_ack
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e        state_q, state_d;
    logic [IDXW-1:0]   win_q, win_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [LENW-1:0]   last_q, last_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic              rx_q, rx_d;
    logic [7:0]        byte_q, byte_d;
    logic [DOUT_W-1:0] rd_q, rd_d;

`ifdef SPI_ARB_CFG_CACHE_EN
    logic [CFG_W-1:0]  cache_q, cache_d;
    logic              cache_vld_q, cache_vld_d;
    logic [CFG_W-1:0]  arb_cfg;
`endif

    logic [NREQ-1:0]   arb_gnt;
    logic [IDXW-1:0]   arb_idx;
    logic              arb_any;
    logic              arb_accept;
    logic [LENW-1:0]   arb_len;
    logic [CFG_W-1:0]  win_cfg;
    logic              is_last;
    logic              is_first;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .accept  (arb_accept),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_req (arb_any)
    );

    assign arb_accept = (state_q == ST_IDLE);
    assign arb_len    = req_len[arb_idx*LENW +: LENW];
    assign win_cfg    = req_cfg[win_q*CFG_W +: CFG_W];
    assign is_last    = (cnt_q == last_q);
    assign is_first   = (cnt_q == '0);
    assign gnt        = gnt_q;
`ifdef SPI_ARB_CFG_CACHE_EN
    assign arb_cfg    = req_cfg[arb_idx*CFG_W +: CFG_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            gnt_q       <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            rx_q        <= 1'b0;
            byte_q      <= '0;
            rd_q        <= '0;
`ifdef SPI_ARB_CFG_CACHE_EN
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            byte_q      <= byte_d;
            rd_q        <= rd_d;
`ifdef SPI_ARB_CFG_CACHE_EN
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        byte_d  = byte_q;
        rd_d    = rd_q;
`ifdef SPI_ARB_CFG_CACHE_EN
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    win_d  = arb_idx;
                    gnt_d  = arb_gnt;
                    cnt_d  = '0;
                    rx_d   = req_rx[arb_idx];
                    // A zero length still moves one byte so SS always opens and closes.
                    last_d = (arb_len == '0) ? '0 : arb_len - LENW'(1);
`ifdef SPI_ARB_CFG_CACHE_EN
                    state_d = (cache_vld_q && (cache_q == arb_cfg)) ? ST_TXW : ST_CFG;
`else
                    state_d = ST_CFG;
`endif
                end
            end
            ST_CFG: begin
`ifdef SPI_ARB_CFG_CACHE_EN
                cache_d     = win_cfg;
                cache_vld_d = 1'b1;
`endif
                state_d = ST_CFG_ACK;
            end
            ST_CFG_ACK: begin
                if (spi_ack) begin
                    state_d = ST_TXW;
                end
            end
            ST_TXW: begin
                if (tx_valid[win_q]) begin
                    byte_d  = tx_data[win_q*8 +: 8];
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                state_d = ST_WR_ACK;
            end
            ST_WR_ACK: begin
                // No ack means the write FIFO was full; the same word is re-issued.
                if (!spi_ack) begin
                    state_d = ST_WR;
                end else if (rx_q) begin
                    state_d = ST_RD;
                end else if (is_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + LENW'(1);
                    state_d = ST_TXW;
                end
            end
            ST_RD: begin
                rd_d    = spi_dout;
                state_d = ST_RD_ACK;
            end
            ST_RD_ACK: begin
                if (rd_q[DOUT_EMPTY]) begin
                    state_d = ST_RD;
                end else if (is_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + LENW'(1);
                    state_d = ST_TXW;
                end
            end
            ST_DONE: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        spi_cmd  = 1'b0;
        spi_wr   = 1'b0;
        spi_rd   = 1'b0;
        spi_din  = '0;
        tx_ready = '0;
        rx_valid = '0;
        rx_data  = '0;
        done     = '0;
        case (state_q)
            ST_CFG: begin
                spi_cmd = 1'b1;
                spi_din = win_cfg;
            end
            ST_TXW: begin
                if (tx_valid[win_q]) begin
                    tx_ready = gnt_q;
                end
            end
            ST_WR: begin
                spi_wr  = 1'b1;
                spi_din = wr_word(rx_q, is_last, is_first, byte_q);
            end
            ST_RD: begin
                spi_rd = 1'b1;
            end
            ST_RD_ACK: begin
                if (!rd_q[DOUT_EMPTY]) begin
                    rx_valid = gnt_q;
                    rx_data  = rd_q[7:0];
                end
            end
            ST_DONE: begin
                done = gnt_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed bench for spi_arbiter with a small spi_if model and loopback MISO
module tb_spi_arbiter;

    localparam int NREQ = 2;
    localparam int LENW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ*11-1:0]   req_cfg;
    logic [NREQ*LENW-1:0] req_len;
    logic [NREQ-1:0]      req_rx;
    logic [NREQ*8-1:0]    tx_data;
    logic [NREQ-1:0]      tx_valid;
    logic [NREQ-1:0]      tx_ready;
    logic [7:0]           rx_data;
    logic [NREQ-1:0]      rx_valid;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      done;
    logic [10:0]          spi_din;
    logic                 spi_cmd;
    logic                 spi_wr;
    logic                 spi_rd;
    logic [8:0]           spi_dout = 9'h100;
    logic                 spi_ack = 1'b0;

    spi_arbiter #(.NREQ(NREQ), .LENW(LENW)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_cfg  (req_cfg),
        .req_len  (req_len),
        .req_rx   (req_rx),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .gnt      (gnt),
        .done     (done),
        .spi_din  (spi_din),
        .spi_cmd  (spi_cmd),
        .spi_wr   (spi_wr),
        .spi_rd   (spi_rd),
        .spi_dout (spi_dout),
        .spi_ack  (spi_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // spi_if model: acks one cycle after an accepted strobe, loops written rx bytes back to MISO
    int         epoch = 0, seen_epoch = 0;
    int         nack_cfg = 0, empty_cfg = 0;
    int         nack_left = 0, empty_left = 0;
    int         wr_strobes = 0, rd_strobes = 0, viol = 0;
    logic       ack_pend = 1'b0, prev_strobe = 1'b0;
    logic [NREQ-1:0] prev_gnt = '0;
    logic [10:0] cmd_log[$];
    logic [10:0] wr_acc_log[$];
    logic [7:0]  rx_log[$];
    logic [7:0]  loop_q[$];
    int          done_log[$];
    int          gnt_log[$];

    always @(negedge clk) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            nack_left  = nack_cfg;
            empty_left = empty_cfg;
            wr_strobes = 0;
            rd_strobes = 0;
            cmd_log.delete();
            wr_acc_log.delete();
            rx_log.delete();
            done_log.delete();
            gnt_log.delete();
        end
        if (rst) begin
            spi_ack     = 1'b0;
            ack_pend    = 1'b0;
            spi_dout    = 9'h100;
            prev_strobe = 1'b0;
            prev_gnt    = '0;
            loop_q.delete();
        end else begin
            spi_ack  = ack_pend;
            ack_pend = 1'b0;
            if (spi_cmd) begin
                cmd_log.push_back(spi_din);
                ack_pend = 1'b1;
            end
            if (spi_wr) begin
                wr_strobes++;
                if (nack_left > 0) nack_left--;
                else begin
                    ack_pend = 1'b1;
                    wr_acc_log.push_back(spi_din);
                    if (spi_din[10]) loop_q.push_back(spi_din[7:0]);
                end
            end
            spi_dout = 9'h100;
            if (spi_rd) begin
                rd_strobes++;
                ack_pend = 1'b1;
                if (empty_left > 0) empty_left--;
                else if (loop_q.size() > 0) spi_dout = {1'b0, loop_q.pop_front()};
            end
            if (rx_valid != '0) rx_log.push_back(rx_data);
            if (done != '0) done_log.push_back(oh_idx(done));
            if (gnt != '0 && prev_gnt == '0) gnt_log.push_back(oh_idx(gnt));
            if ((int'(spi_cmd) + int'(spi_wr) + int'(spi_rd)) > 1) viol++;
            if (prev_strobe && (spi_cmd || spi_wr || spi_rd)) viol++;
            if (((tx_ready | rx_valid | done) & ~gnt) != '0) viol++;
            if ((gnt & (gnt - 1'b1)) != '0) viol++;
            prev_strobe = spi_cmd || spi_wr || spi_rd;
            prev_gnt    = gnt;
        end
    end

    logic abort = 1'b0;

    task automatic run_req(input int idx, input logic [10:0] cfg, input logic [7:0] len,
                           input logic rx, input logic [3:0][7:0] bytes);
        int k;
        int cyc;
        bit adv;
        bit fin;
        k = 0; cyc = 0; adv = 0; fin = 0;
        req_cfg[idx*11 +: 11] = cfg;
        req_len[idx*8 +: 8]   = len;
        req_rx[idx]           = rx;
        tx_data[idx*8 +: 8]   = bytes[0];
        tx_valid[idx]         = 1'b1;
        req[idx]              = 1'b1;
        while (!fin && !abort && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (adv && k < 3) begin
                k++;
                tx_data[idx*8 +: 8] = bytes[k];
            end
            adv = 0;
            if (tx_ready[idx]) adv = 1;
            if (done[idx]) fin = 1;
        end
        req[idx]      = 1'b0;
        tx_valid[idx] = 1'b0;
        if (!abort) check($sformatf("done_seen_req%0d", idx), 32'(fin), 32'd1);
    endtask

    typedef struct {
        int               idx;
        logic [10:0]      cfg;
        logic [7:0]       len;
        logic             rx;
        logic [3:0][7:0]  bytes;
        int               nack;
        int               empty;
        int               n_wr;
        logic [3:0][10:0] exp_wr;
        int               n_rx;
        logic [3:0][7:0]  exp_rx;
    } vec_t;

    vec_t        vecs[6];
    logic [10:0] cache_cfg = '0;
    logic        cache_vld = 1'b0;
    int          exp_cmd;
    bit          found;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; req_cfg = '0; req_len = '0; req_rx = '0; tx_data = '0; tx_valid = '0;

        vecs[0] = '{0, 11'h0A1, 8'd1, 1'b0, {8'h00, 8'h00, 8'h00, 8'h5A}, 0, 0,
                    1, {11'h000, 11'h000, 11'h000, 11'h35A}, 0, 32'h0};
        vecs[1] = '{0, 11'h0A1, 8'd3, 1'b1, {8'h00, 8'h33, 8'h22, 8'h11}, 0, 0,
                    3, {11'h000, 11'h633, 11'h422, 11'h511}, 3, {8'h00, 8'h33, 8'h22, 8'h11}};
        vecs[2] = '{1, 11'h155, 8'd2, 1'b0, {8'h00, 8'h00, 8'h0B, 8'hA0}, 2, 0,
                    2, {11'h000, 11'h000, 11'h20B, 11'h1A0}, 0, 32'h0};
        vecs[3] = '{0, 11'h155, 8'd0, 1'b0, {8'h00, 8'h00, 8'h00, 8'h77}, 0, 0,
                    1, {11'h000, 11'h000, 11'h000, 11'h377}, 0, 32'h0};
        vecs[4] = '{1, 11'h7FF, 8'd2, 1'b1, {8'h00, 8'h00, 8'h3C, 8'hC3}, 0, 2,
                    2, {11'h000, 11'h000, 11'h63C, 11'h5C3}, 2, {8'h00, 8'h00, 8'h3C, 8'hC3}};
        vecs[5] = '{0, 11'h7FF, 8'd1, 1'b1, {8'h00, 8'h00, 8'h00, 8'hFF}, 1, 0,
                    1, {11'h000, 11'h000, 11'h000, 11'h7FF}, 1, {8'h00, 8'h00, 8'h00, 8'hFF}};

        repeat (3) @(negedge clk);
        check("reset_outputs_in_rst", 32'({gnt, done, tx_ready, rx_valid, rx_data, spi_din, spi_cmd, spi_wr, spi_rd}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_strobes", 32'({spi_cmd, spi_wr, spi_rd, spi_din}), 32'd0);

        for (int v = 0; v < 6; v++) begin
            nack_cfg  = vecs[v].nack;
            empty_cfg = vecs[v].empty;
            epoch++;
            @(negedge clk);
            run_req(vecs[v].idx, vecs[v].cfg, vecs[v].len, vecs[v].rx, vecs[v].bytes);
            repeat (2) @(negedge clk);
`ifdef SPI_ARB_CFG_CACHE_EN
            exp_cmd = (cache_vld && cache_cfg == vecs[v].cfg) ? 0 : 1;
`else
            exp_cmd = 1;
`endif
            cache_cfg = vecs[v].cfg;
            cache_vld = 1'b1;
            check($sformatf("v%0d_cmd_count", v), 32'(cmd_log.size()), 32'(exp_cmd));
            if (exp_cmd == 1)
                check($sformatf("v%0d_cmd_din", v), cmd_log.size() > 0 ? 32'(cmd_log[0]) : 32'hDEAD, 32'(vecs[v].cfg));
            check($sformatf("v%0d_wr_count", v), 32'(wr_acc_log.size()), 32'(vecs[v].n_wr));
            for (int i = 0; i < vecs[v].n_wr; i++)
                check($sformatf("v%0d_wr%0d_din", v, i),
                      i < wr_acc_log.size() ? 32'(wr_acc_log[i]) : 32'hDEAD, 32'(vecs[v].exp_wr[i]));
            check($sformatf("v%0d_wr_strobes", v), 32'(wr_strobes), 32'(vecs[v].n_wr + vecs[v].nack));
            check($sformatf("v%0d_rd_strobes", v), 32'(rd_strobes),
                  vecs[v].rx ? 32'(vecs[v].n_wr + vecs[v].empty) : 32'd0);
            check($sformatf("v%0d_rx_count", v), 32'(rx_log.size()), 32'(vecs[v].n_rx));
            for (int i = 0; i < vecs[v].n_rx; i++)
                check($sformatf("v%0d_rx%0d_data", v, i),
                      i < rx_log.size() ? 32'(rx_log[i]) : 32'hDEAD, 32'(vecs[v].exp_rx[i]));
            check($sformatf("v%0d_done_once", v), 32'(done_log.size()), 32'd1);
            check($sformatf("v%0d_done_idx", v), done_log.size() > 0 ? 32'(done_log[0]) : 32'hDEAD, 32'(vecs[v].idx));
            check($sformatf("v%0d_gnt_idx", v), gnt_log.size() > 0 ? 32'(gnt_log[0]) : 32'hDEAD, 32'(vecs[v].idx));
        end

        // fairness: both requesters raised together, twice, starting from rr pointer 0
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cache_vld = 1'b0;
        nack_cfg = 0; empty_cfg = 0;
        epoch++;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            fork
                run_req(0, 11'h0A1, 8'd1, 1'b0, {8'h00, 8'h00, 8'h00, 8'hE0});
                run_req(1, 11'h0A1, 8'd1, 1'b0, {8'h00, 8'h00, 8'h00, 8'hE1});
            join
        end
        repeat (2) @(negedge clk);
        check("fair_grants", 32'(gnt_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fair_gnt%0d", i), i < gnt_log.size() ? 32'(gnt_log[i]) : 32'hDEAD, 32'(i % 2));
            check($sformatf("fair_wr%0d", i), i < wr_acc_log.size() ? 32'(wr_acc_log[i]) : 32'hDEAD,
                  (i % 2 == 0) ? 32'h3E0 : 32'h3E1);
        end
`ifdef SPI_ARB_CFG_CACHE_EN
        check("fair_cmd_count", 32'(cmd_log.size()), 32'd1);
`else
        check("fair_cmd_count", 32'(cmd_log.size()), 32'd4);
`endif

        // reset while waiting for the ack of byte 2 of 4
        epoch++;
        @(negedge clk);
        fork
            run_req(0, 11'h0A1, 8'd4, 1'b0, {8'hB4, 8'hB3, 8'hB2, 8'hB1});
            begin
                found = 0;
                for (int c = 0; c < 300 && !found; c++) begin
                    @(negedge clk);
                    if (spi_wr && spi_din[7:0] == 8'hB2) found = 1;
                end
                check("rstmid_reached_byte2", 32'(found), 32'd1);
                @(negedge clk);
                rst   = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                check("rstmid_outputs_zero",
                      32'({gnt, done, tx_ready, rx_valid, rx_data, spi_din, spi_cmd, spi_wr, spi_rd}), 32'd0);
            end
        join
        @(negedge clk);
        rst   = 1'b0;
        abort = 1'b0;
        cache_vld = 1'b0;
        epoch++;
        @(negedge clk);
        run_req(0, 11'h0A1, 8'd2, 1'b0, {8'h00, 8'h00, 8'hD2, 8'hD1});
        repeat (2) @(negedge clk);
        check("rstmid_restart_cmd", 32'(cmd_log.size()), 32'd1);
        check("rstmid_restart_cmd_din", cmd_log.size() > 0 ? 32'(cmd_log[0]) : 32'hDEAD, 32'h0A1);
        check("rstmid_restart_wr_count", 32'(wr_acc_log.size()), 32'd2);
        check("rstmid_restart_first", wr_acc_log.size() > 0 ? 32'(wr_acc_log[0]) : 32'hDEAD, 32'h1D1);
        check("rstmid_restart_last", wr_acc_log.size() > 1 ? 32'(wr_acc_log[1]) : 32'hDEAD, 32'h2D2);

        check("protocol_violations", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
